// File: rtl/usb_tx_arb.sv
// usb_tx_arb: round-robin sharing of one UTMI transmit port between NREQ packet sources.
//  clk, rst (async, active-high), tx_en: allow new grants
//  req_valid/req_data/req_last: per-lane byte stream in; req_ready: per-lane byte consumed
//  DataOut_o/TxValid_o/TxReady_i: UTMI transmit handshake
//  gnt_o: one-hot owner; pkt_done_o: last byte taken; underrun_o: owner starved the PHY
module usb_tx_arb #(
  parameter int NREQ    = 2,
  parameter int GAP_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        DataOut_o,
  output logic              TxValid_o,
  input  logic              TxReady_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              pkt_done_o,
  output logic              underrun_o
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [7:0] GAP_LD = 8'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state;
  logic [PW-1:0] ptr, own, pick, idx;
  logic found, last_r, take_new, take_next;
  logic [7:0] cnt;
  logic [7:0] lane_data [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_data[i] = req_data[8*i +: 8];
  end
  // descending scan so the lane nearest ptr+1 wins
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // the final gap cycle doubles as an arbitration slot so TxValid_o stays low exactly GAP_CYC cycles
  assign take_new  = (state == IDLE || (state == GAP && cnt == 8'd0)) && tx_en && found;
  assign take_next = state == XFER && TxReady_i && !last_r && req_valid[own];
  assign req_ready = take_new ? NREQ'(1) << pick : take_next ? NREQ'(1) << own : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= PW'(NREQ - 1);
      own <= '0;
      last_r <= 1'b0;
      cnt <= '0;
      DataOut_o <= '0;
      TxValid_o <= 1'b0;
      gnt_o <= '0;
      pkt_done_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      pkt_done_o <= 1'b0;
      underrun_o <= 1'b0;
      if (take_new) begin
        state <= XFER;
        ptr <= pick;
        own <= pick;
        gnt_o <= NREQ'(1) << pick;
        DataOut_o <= lane_data[pick];
        last_r <= req_last[pick];
        TxValid_o <= 1'b1;
      end else if (state == XFER && TxReady_i) begin
        if (take_next) begin
          DataOut_o <= lane_data[own];
          last_r <= req_last[own];
        end else begin
          state <= GAP;
          cnt <= GAP_LD;
          TxValid_o <= 1'b0;
          gnt_o <= '0;
          pkt_done_o <= last_r;
          underrun_o <= !last_r;
        end
      end else if (state == GAP) begin
        state <= cnt == 8'd0 ? IDLE : GAP;
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_arb.sv
// tb_usb_tx_arb: scoreboard bench for usb_tx_arb (GAP_CYC=4 main instance, GAP_CYC=0 side instance).
module tb_usb_tx_arb;
  logic clk = 0, rst = 1, tx_en = 0;
  logic [1:0] req_valid = 0, req_last = 0, req_ready, gnt_o;
  logic [15:0] req_data = 0;
  logic TxReady_i = 0, TxValid_o, pkt_done_o, underrun_o;
  logic [7:0] DataOut_o;
  logic [1:0] v0 = 0, l0 = 2'b01, rdy0, gnt0;
  logic [15:0] d0 = 16'h00ab;
  logic txr0 = 1, txv0, done0, und0;
  logic [7:0] dout0;
  always #5 clk = ~clk;
  usb_tx_arb #(.NREQ(2), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .DataOut_o(DataOut_o), .TxValid_o(TxValid_o),
    .TxReady_i(TxReady_i), .gnt_o(gnt_o), .pkt_done_o(pkt_done_o), .underrun_o(underrun_o)
  );
  usb_tx_arb #(.NREQ(2), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .req_valid(v0), .req_data(d0),
    .req_last(l0), .req_ready(rdy0), .DataOut_o(dout0), .TxValid_o(txv0),
    .TxReady_i(txr0), .gnt_o(gnt0), .pkt_done_o(done0), .underrun_o(und0)
  );
  typedef struct packed {logic [1:0] k; logic [1:0] g; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  logic [8:0] lq [2][$];
  logic [1:0] rdy_s = 0;
  int n_cmp = 0, n_bad = 0, rdy_per = 0, cyc = 0, low_run = 0;
  bit gap_chk = 0, seen_hi = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic void src(input int lane, input logic [7:0] d, input bit last);
    lq[lane].push_back({last, d});
  endfunction
  function automatic void exb(input int lane, input logic [7:0] d);
    exp_q.push_back({2'd0, 2'(1 << lane), d});
  endfunction
  function automatic void exk(input logic [1:0] k);
    exp_q.push_back({k, 2'd0, 8'd0});
  endfunction
  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask
  task automatic wait_tx(input string nm);
    int n = 0;
    while (!TxValid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(TxValid_o), 1);
  endtask
  // sources and PHY: drive just after each rising edge; consume what req_ready offered before it
  always @(negedge clk) rdy_s <= req_ready;
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst && rdy_s[i] && lq[i].size() > 0) void'(lq[i].pop_front());
      req_valid[i] = lq[i].size() > 0;
      {req_last[i], req_data[8*i +: 8]} = lq[i].size() > 0 ? lq[i][0] : 9'h0;
    end
    TxReady_i = rdy_per > 0 && (cyc % rdy_per == rdy_per - 1);
  end
  // monitor: pulses and accepted bytes are popped from the scoreboard in order
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_done_o || underrun_o) begin
        chk("txvalid_low_at_pulse", 32'(TxValid_o), 0);
        if (exp_q.size() == 0) chk("unexpected_pulse", 32'({underrun_o, pkt_done_o}), 0);
        else begin
          e_m = exp_q.pop_front();
          chk("pulse_kind", 32'({underrun_o, pkt_done_o}), 32'(e_m.k));
        end
      end
      if (TxValid_o && TxReady_i) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'({1'b1, gnt_o, DataOut_o}), 0);
        else begin
          e_m = exp_q.pop_front();
          chk("byte", 32'({2'b00, gnt_o, DataOut_o}), 32'(e_m));
        end
      end
      if (TxValid_o) begin
        if (gap_chk && seen_hi && low_run > 0) chk("gap_len", 32'(low_run), 4);
        seen_hi = gap_chk;
        low_run = 0;
      end else low_run++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int low, rises;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({DataOut_o, TxValid_o, gnt_o, pkt_done_o, underrun_o, req_ready}), 0);
    rst = 0;
    tx_en = 1;
    rdy_per = 8;
    src(0, 8'ha1, 0); src(0, 8'hb2, 0); src(0, 8'hc3, 1);
    exb(0, 8'ha1); exb(0, 8'hb2); exb(0, 8'hc3); exk(1);
    drain("t1_drain");
    rdy_per = 1;
    gap_chk = 1;
    src(0, 8'h10, 1); src(0, 8'h20, 1); src(1, 8'h11, 1); src(1, 8'h21, 1);
    exb(1, 8'h11); exk(1); exb(0, 8'h10); exk(1); exb(1, 8'h21); exk(1); exb(0, 8'h20); exk(1);
    drain("t2_drain");
    gap_chk = 0;
    src(1, 8'h55, 0);
    exb(1, 8'h55); exk(2);
    drain("t3_drain");
    rdy_per = 3;
    src(0, 8'hd1, 0); src(0, 8'hd2, 0); src(0, 8'hd3, 1);
    exb(0, 8'hd1); exb(0, 8'hd2); exb(0, 8'hd3); exk(1);
    wait_tx("t4_granted");
    @(posedge clk);
    #2 tx_en = 0;
    src(1, 8'he1, 1);
    drain("t4_drain");
    repeat (12) @(negedge clk);
    chk("t4_hold_idle", 32'({TxValid_o, gnt_o}), 0);
    chk("t4_hold_queued", 32'(lq[1].size()), 1);
    exb(1, 8'he1); exk(1);
    @(posedge clk);
    #2 tx_en = 1;
    drain("t4b_drain");
    rdy_per = 0;
    src(0, 8'h77, 0); src(0, 8'h88, 1);
    wait_tx("t5_granted");
    @(negedge clk);
    #2 rst = 1;
    #1 chk("t5_async_clear", 32'({TxValid_o, gnt_o}), 0);
    lq[0].delete();
    lq[1].delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    rdy_per = 1;
    src(0, 8'ha0, 1); src(1, 8'hb0, 1);
    exb(0, 8'ha0); exk(1); exb(1, 8'hb0); exk(1);
    drain("t5_drain");
    @(negedge clk);
    v0 = 2'b01;
    low = 0;
    while (!txv0 && low < 50) begin
      @(negedge clk);
      low++;
    end
    chk("t6_granted", 32'({txv0, dout0}), 32'h1ab);
    low = 0;
    rises = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (txv0) begin
        if (low > 0) begin
          chk("t6_gap_len", 32'(low), 1);
          rises++;
        end
        low = 0;
      end else low++;
    end
    chk("t6_packets", 32'(rises), 8);
    v0 = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
